chip8_i2s_dac: RTL and testbench

- Downstream stage of the beep-sample generator: consumes its 16-bit samples and serializes them to the audio codec DAC in I2S format.
- Generates the codec bit clock (BCLK), the left/right clock (DACLRCK) and the serial data line (DACDAT).
- Issues the sample_req and sample_end strobes that pace the generator.
- Mono: the same sample is sent on both channels. Runs on the audio clock domain.

---
 rtl/chip8_audio_pkg.sv | 22 ++
 rtl/chip8_i2s_clkgen.sv | 69 ++++++
 rtl/chip8_i2s_dac.sv | 161 ++++++++++++++++
 tb/tb_chip8_i2s_dac.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_audio_pkg.sv
// Shared types and default constants for the CHIP-8 audio output path.
package chip8_audio_pkg;

  typedef logic signed [15:0] audio_sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  localparam int BCLK_DIV_DEFAULT  = 4;
  localparam int SAMPLE_W_DEFAULT  = 16;
  localparam int SLOT_BITS_DEFAULT = 32;
  localparam int REQ_BIT_DEFAULT   = 40;
  localparam int LATCH_BIT_DEFAULT = 48;

  // Position of a frame bit inside its channel slot (0 = first bit of the slot).
  function automatic int slot_pos(input int frame_bit, input int slot_bits);
    return (frame_bit >= slot_bits) ? (frame_bit - slot_bits) : frame_bit;
  endfunction

endpackage

// File: rtl/chip8_i2s_clkgen.sv
// BCLK divider and frame bit counter for the I2S DAC stage.
// Counters sit at zero with BCLK parked low whenever run_i is low.
// Optional feature macro: CHIP8_I2S_ADC_CAPTURE_EN (adds rise_o and bit_o).
module chip8_i2s_clkgen
  import chip8_audio_pkg::*;
#(
  parameter int BCLK_DIV  = BCLK_DIV_DEFAULT,
  parameter int SLOT_BITS = SLOT_BITS_DEFAULT,
  parameter int BIT_W     = $clog2(2 * SLOT_BITS_DEFAULT)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             run_i,
  output logic             bclk_o,
  output logic             lrck_o,
  output logic             fall_o,
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  output logic             rise_o,
  output logic [BIT_W-1:0] bit_o,
`endif
  output logic [BIT_W-1:0] next_bit_o,
  output logic             frame_wrap_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             bclk_q;
  logic             lrck_q;
  logic [BIT_W-1:0] bit_q;
  logic             div_wrap;
  logic [BIT_W-1:0] nxt_bit;

  // Decode the divider wrap, the BCLK edge events and the bit being entered.
  always_comb begin
    div_wrap     = run_i && (div_q == DIV_W'(BCLK_DIV - 1));
    fall_o       = div_wrap && bclk_q;
    frame_wrap_o = fall_o && (bit_q == BIT_W'(2 * SLOT_BITS - 1));
    nxt_bit      = frame_wrap_o ? '0 : bit_q + BIT_W'(1);
  end

  // Divider, BCLK toggle, and bit counter / LRCK advancing on BCLK falls.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || !run_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) begin
        bclk_q <= ~bclk_q;
      end
      if (fall_o) begin
        bit_q  <= nxt_bit;
        lrck_q <= (int'(nxt_bit) >= SLOT_BITS);
      end
    end
  end

  assign bclk_o     = bclk_q;
  assign lrck_o     = lrck_q;
  assign next_bit_o = nxt_bit;
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  assign rise_o     = div_wrap && !bclk_q;
  assign bit_o      = bit_q;
`endif

endmodule

// File: rtl/chip8_i2s_dac.sv
// I2S serializer for the CHIP-8 beep generator: mono sample on both slots,
// MSB first with the one-bit I2S delay, plus sample_req/sample_end pacing.
// Handshake: sample_req is a one-clk request; the generator must hold
// sample_in stable from REQ_BIT+2 clk until the capture at LATCH_BIT.
// Optional feature macro: CHIP8_I2S_ADC_CAPTURE_EN (ADC capture path).
module chip8_i2s_dac
  import chip8_audio_pkg::*;
#(
  parameter int BCLK_DIV  = BCLK_DIV_DEFAULT,
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int SLOT_BITS = SLOT_BITS_DEFAULT,
  parameter int REQ_BIT   = REQ_BIT_DEFAULT,
  parameter int LATCH_BIT = LATCH_BIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_req,
  output logic                sample_end,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat,
  output logic                busy,
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  input  logic                aud_adcdat,
  output logic                aud_adclrck,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
`endif
  output i2s_state_t          dbg_state
);

  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  i2s_state_t          state_q;
  logic [SAMPLE_W-1:0] latch_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic                dacdat_q;
  logic                req_q;

  logic                fall;
  logic                frame_wrap;
  logic                lrck;
  logic                bclk;
  logic [BIT_W-1:0]    next_bit;
  int                  nxt_bit_int;
  int                  nxt_pos;
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  logic                rise;
  logic [BIT_W-1:0]    cur_bit;
`endif

  chip8_i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS),
    .BIT_W    (BIT_W)
  ) u_clkgen (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .run_i       (state_q == RUN),
    .bclk_o      (bclk),
    .lrck_o      (lrck),
    .fall_o      (fall),
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
    .rise_o      (rise),
    .bit_o       (cur_bit),
`endif
    .next_bit_o  (next_bit),
    .frame_wrap_o(frame_wrap)
  );

  // Frame bit and slot position that the next BCLK fall moves into.
  always_comb begin
    nxt_bit_int = int'(next_bit);
    nxt_pos     = slot_pos(nxt_bit_int, SLOT_BITS);
  end

  // Control FSM with shift register, sample latch and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      latch_q  <= '0;
      shift_q  <= '0;
      dacdat_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dacdat_q <= 1'b0;
          if (enable) begin
            state_q <= RUN;
            shift_q <= latch_q;
          end
        end
        RUN: begin
          if (fall) begin
            req_q <= (nxt_bit_int == REQ_BIT);
            if (nxt_bit_int == LATCH_BIT) begin
              latch_q <= sample_in;
            end
            if (nxt_pos == 0) begin
              // Both slots start from the same latched sample.
              shift_q  <= latch_q;
              dacdat_q <= 1'b0;
            end else if (nxt_pos <= SAMPLE_W) begin
              dacdat_q <= shift_q[SAMPLE_W-1];
              shift_q  <= {shift_q[SAMPLE_W-2:0], 1'b0};
            end else begin
              dacdat_q <= 1'b0;
            end
          end
          // Frames always run to completion; enable is only looked at here.
          if (frame_wrap && !enable) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_req  = req_q;
  assign sample_end  = frame_wrap;
  assign aud_bclk    = bclk;
  assign aud_daclrck = lrck;
  assign aud_dacdat  = dacdat_q;
  assign busy        = (state_q == RUN);
  assign dbg_state   = state_q;

`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  logic [SAMPLE_W-1:0] adc_shift_q;
  logic [SAMPLE_W-1:0] adc_out_q;
  logic                adc_valid_q;

  // Shift left-slot ADC bits on BCLK rises and publish once per frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adc_shift_q <= '0;
      adc_out_q   <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      adc_valid_q <= 1'b0;
      if ((state_q == RUN) && rise && (int'(cur_bit) >= 1) &&
          (int'(cur_bit) <= SAMPLE_W)) begin
        adc_shift_q <= {adc_shift_q[SAMPLE_W-2:0], aud_adcdat};
      end
      if (frame_wrap) begin
        adc_out_q   <= adc_shift_q;
        adc_valid_q <= 1'b1;
      end
    end
  end

  assign aud_adclrck      = lrck;
  assign sample_out       = adc_out_q;
  assign sample_out_valid = adc_valid_q;
`endif

endmodule

// File: tb/tb_chip8_i2s_dac.sv
// Bench for chip8_i2s_dac: frame-time model driving an expected queue, a
// per-cycle compare, a frame observer and directed literal checks.
module tb_chip8_i2s_dac;
  import chip8_audio_pkg::*;

  localparam int D      = 2;
  localparam int SLOT   = 32;
  localparam int SW     = 16;
  localparam int REQ    = 40;
  localparam int LAT    = 48;
  localparam int BITLEN = 2 * D;
  localparam int FRAME  = 2 * SLOT * BITLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic [SW-1:0] sample_in;
  logic sample_req, sample_end, aud_bclk, aud_daclrck, aud_dacdat, busy;
  i2s_state_t dbg_state;
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
  logic aud_adcdat = 1'b1;
  logic aud_adclrck;
  logic [SW-1:0] sample_out;
  logic sample_out_valid;
`endif

  always #5 clk = ~clk;

  chip8_i2s_dac #(
    .BCLK_DIV (D),
    .SAMPLE_W (SW),
    .SLOT_BITS(SLOT),
    .REQ_BIT  (REQ),
    .LATCH_BIT(LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .sample_in       (sample_in),
    .sample_req      (sample_req),
    .sample_end      (sample_end),
    .aud_bclk        (aud_bclk),
    .aud_daclrck     (aud_daclrck),
    .aud_dacdat      (aud_dacdat),
    .busy            (busy),
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
    .aud_adcdat      (aud_adcdat),
    .aud_adclrck     (aud_adclrck),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors    = 0;
  int miscompares = 0;
  logic [5:0] exp_q[$];

  task automatic check_int(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] act_vec();
    return {busy, aud_bclk, aud_daclrck, aud_dacdat, sample_req, sample_end};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        run;
    int        t;
    logic [15:0] cur;
    logic [15:0] nxt;
  } model_t;

  model_t m = '{run: 1'b0, t: 0, cur: 16'h0, nxt: 16'h0};

  // Outputs as a function of time within the frame and the frame's sample.
  function automatic logic [5:0] model_out(input bit run, input int t, input logic [15:0] s);
    int b, p;
    logic bclk, lrck, dat, req, fin;
    if (!run) return 6'b0;
    b    = t / BITLEN;
    p    = b % SLOT;
    bclk = ((t / D) % 2) == 1;
    lrck = (b >= SLOT);
    dat  = (p >= 1 && p <= SW) ? s[SW-p] : 1'b0;
    req  = (t == REQ * BITLEN);
    fin  = (t == FRAME - 1);
    return {1'b1, bclk, lrck, dat, req, fin};
  endfunction

  function automatic model_t model_next(input model_t c, input logic rn, input logic en,
                                        input logic [15:0] s);
    model_t n = c;
    if (!rn) begin
      n.run = 1'b0; n.t = 0; n.cur = 16'h0; n.nxt = 16'h0;
    end else if (!c.run) begin
      if (en) begin n.run = 1'b1; n.t = 0; n.cur = c.nxt; end
    end else begin
      if (c.t == LAT * BITLEN - 1) n.nxt = s;
      if (c.t == FRAME - 1) begin
        n.t = 0; n.cur = n.nxt;
        if (!en) n.run = 1'b0;
      end else begin
        n.t = c.t + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, reset_n, enable, sample_in);
    exp_q.push_back(model_out(model_next(m, reset_n, enable, sample_in).run,
                              model_next(m, reset_n, enable, sample_in).t,
                              model_next(m, reset_n, enable, sample_in).cur));
  end

  task automatic check_vec(input logic [5:0] e);
    check_int("cycle{busy,bclk,lrck,dat,req,end}", act_vec(), e);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_vec(exp_q.pop_front());
  end

  // ---------------- frame observer ----------------
  int t_obs   = 0;
  int req_cnt = 0;
  int end_cnt = 0;
  logic [31:0] frame_left[8];
  logic [31:0] frame_right[8];

  // Collects per-frame slot data and checks strobe positions within a frame.
  always @(negedge clk) begin
    if (busy) begin
      t_obs <= t_obs + 1;
      if ((t_obs % BITLEN == 0) && (t_obs / FRAME < 8)) begin
        if ((t_obs / BITLEN) % 64 < 32)
          frame_left[t_obs / FRAME][31 - (t_obs / BITLEN) % 64] <= aud_dacdat;
        else
          frame_right[t_obs / FRAME][63 - (t_obs / BITLEN) % 64] <= aud_dacdat;
      end
      if (sample_req) begin
        req_cnt <= req_cnt + 1;
        check_int("req_position", t_obs % FRAME, REQ * BITLEN);
      end
      if (sample_end) begin
        end_cnt <= end_cnt + 1;
        check_int("end_position", t_obs % FRAME, FRAME - 1);
      end
`ifdef CHIP8_I2S_ADC_CAPTURE_EN
      if (sample_out_valid) check_int("adc_sample_out", sample_out, 16'hFFFF);
`endif
    end else begin
      t_obs <= 0;
    end
  end

  // ---------------- driver ----------------
  int now_t = 0;

  task automatic goto(input int t);
    repeat (t - now_t) @(negedge clk);
    now_t = t;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    now_t = now_t + n;
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    sample_in = 16'hA5C3;

    // Pin the model on a few hand-worked points.
    check_int("model_pin_req",  model_out(1'b1, 160, 16'h0000), 6'b101010);
    check_int("model_pin_msb",  model_out(1'b1, 6,   16'hA5C3), 6'b110100);
    check_int("model_pin_end",  model_out(1'b1, 255, 16'h0000), 6'b111001);

    // Reset hold with enable high.
    repeat (5) @(negedge clk);
    check_int("reset_hold", act_vec(), 6'b0);

    // Stream: frame 0 sends the cleared latch, frame 1 A5C3.
    reset_n = 1'b1;
    now_t   = -1;
    goto(FRAME + 168);  sample_in = 16'h7FFF;
    goto(FRAME + 188);  sample_in = 16'h8000;   // bit 47: captured at 48
    goto(2 * FRAME + 200); sample_in = 16'h1234; // bit 50: too late for frame 3
    goto(4 * FRAME + 40);  enable = 1'b0;       // bit 10 of frame 4
    goto(4 * FRAME + 80);  enable = 1'b1;
    goto(4 * FRAME + 120); enable = 1'b0;
    goto(5 * FRAME + 20);

    check_int("frame0_left",  frame_left[0],  32'h0000_0000);
    check_int("frame1_left",  frame_left[1],  32'h52E1_8000);
    check_int("frame1_right", frame_right[1], 32'h52E1_8000);
    check_int("frame2_left",  frame_left[2],  32'h4000_0000);
    check_int("frame3_left",  frame_left[3],  32'h4000_0000);
    check_int("frame4_left",  frame_left[4],  32'h091A_0000);
    check_int("frame4_right", frame_right[4], 32'h091A_0000);
    check_int("req_count",    req_cnt, 5);
    check_int("end_count",    end_cnt, 5);
    check_int("idle_outputs", act_vec(), 6'b0);

    // Restart, then reset mid-frame at bit 30.
    enable = 1'b1;
    now_t  = -1;
    goto(120);
    check_int("restart_left", frame_left[0], 32'h091A_0000);
    reset_n = 1'b0;
    step(1);
    check_int("reset_abort_outputs", act_vec(), 6'b0);
    step(2);
    check_int("reset_abort_no_end", end_cnt, 5);

    // Run from a cleared latch; drop enable exactly on the wrap clk.
    reset_n = 1'b1;
    now_t   = -1;
    goto(FRAME - 1);
    enable = 1'b0;
    goto(FRAME + 40);
    check_int("cleared_latch_left", frame_left[0], 32'h0000_0000);
    check_int("wrap_drop_end_count", end_cnt, 6);
    check_int("wrap_drop_req_count", req_cnt, 6);
    check_int("wrap_drop_idle", act_vec(), 6'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
